// File: rtl/sec_lut_search_ctrl.sv
// ---------------------------------------------------------------------------
// sec_lut_search_ctrl
//
// Sequential single-error-correction controller for the 24-bit AN code with
// A = 3349. A received codeword is reduced mod A by serial shift-subtract,
// one bit per cycle, MSB first. A nonzero remainder is the syndrome. The
// external l-LUT is then swept through the locations +1,-1,+2,-2,...,+24,-24
// until its remainder equals the syndrome. The matching location selects a
// +/-2^k correction, which is range-checked before it is applied.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : codeword offered
//   in_ready     : high only while idle
//   in_code      : received codeword (unsigned, 24 bits)
//   lut_l        : signed location driven to the l-LUT, 0 outside the search
//   lut_r        : l-LUT remainder for lut_l (combinational, same cycle)
//   out_valid    : result valid, held until out_ready
//   out_ready    : consumer accepts the result
//   out_code     : corrected codeword (input unchanged unless status = 01)
//   out_loc      : signed error location, 0 if none or uncorrectable
//   out_status   : 00 no error, 01 corrected, 10 uncorrectable
// ---------------------------------------------------------------------------
module sec_lut_search_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_code,
    output logic [5:0]  lut_l,
    input  logic [11:0] lut_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_code,
    output logic [5:0]  out_loc,
    output logic [1:0]  out_status
);

    localparam logic [12:0] A_MOD    = 13'd3349;
    localparam logic [5:0]  LAST_IDX = 6'd47;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REM    = 3'd1;
    localparam logic [2:0] S_SEARCH = 3'd2;
    localparam logic [2:0] S_CORR   = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_FIXED = 2'b01;
    localparam logic [1:0] ST_BAD   = 2'b10;

    logic [2:0]  r_state;
    logic [23:0] r_code;
    logic [11:0] r_rem;
    logic [4:0]  r_cnt;
    logic [5:0]  r_idx;
    logic [5:0]  r_loc;
    logic [23:0] r_out_code;
    logic [5:0]  r_out_loc;
    logic [1:0]  r_out_status;

    // Shift-subtract step: the remainder stays below A, so a single
    // conditional subtraction keeps it reduced after each new bit.
    logic [12:0] w_rem_sh;
    logic [11:0] w_rem_next;
    assign w_rem_sh   = {r_rem, r_code[r_cnt]};
    assign w_rem_next = 12'((w_rem_sh >= A_MOD) ? (w_rem_sh - A_MOD) : w_rem_sh);

    // Search order: even idx -> +(idx/2+1), odd idx -> -(idx/2+1).
    logic [5:0] w_mag;
    logic [5:0] w_lut_l;
    assign w_mag   = {1'b0, r_idx[5:1]} + 6'd1;
    assign w_lut_l = r_idx[0] ? (6'd0 - w_mag) : w_mag;

    // Correction: a positive location means an added +2^k error, so it is
    // removed by subtraction. Two guard bits expose under- and overflow.
    logic [5:0]  w_abs_loc;
    logic [25:0] w_e;
    logic [25:0] w_corr;
    logic        w_corr_bad;
    assign w_abs_loc  = r_loc[5] ? (6'd0 - r_loc) : r_loc;
    assign w_e        = 26'd1 << (w_abs_loc - 6'd1);
    assign w_corr     = r_loc[5] ? ({2'b00, r_code} + w_e) : ({2'b00, r_code} - w_e);
    assign w_corr_bad = w_corr[25] | w_corr[24];

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_OUT);
    assign lut_l      = (r_state == S_SEARCH) ? w_lut_l : 6'd0;
    assign out_code   = r_out_code;
    assign out_loc    = r_out_loc;
    assign out_status = r_out_status;

    // NOTE: state is updated with non-blocking assignments so every register
    // in this block sees the pre-edge values of the others, exactly as the
    // hardware flops do; blocking here would chain updates within one edge.
    // NOTE: the datapath registers are reset along with the FSM because the
    // result outputs must read zero after reset and any in-flight word must be
    // dropped; there is no storage array here for which that would be costly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_code       <= 24'd0;
            r_rem        <= 12'd0;
            r_cnt        <= 5'd0;
            r_idx        <= 6'd0;
            r_loc        <= 6'd0;
            r_out_code   <= 24'd0;
            r_out_loc    <= 6'd0;
            r_out_status <= ST_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_code  <= in_code;
                        r_rem   <= 12'd0;
                        r_cnt   <= 5'd23;
                        r_state <= S_REM;
                    end
                end
                S_REM: begin
                    r_rem <= w_rem_next;
                    if (r_cnt == 5'd0) begin
                        if (w_rem_next == 12'd0) begin
                            r_out_code   <= r_code;
                            r_out_loc    <= 6'd0;
                            r_out_status <= ST_OK;
                            r_state      <= S_OUT;
                        end else begin
                            r_idx   <= 6'd0;
                            r_state <= S_SEARCH;
                        end
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_SEARCH: begin
                    if (lut_r == r_rem) begin
                        r_loc   <= w_lut_l;
                        r_state <= S_CORR;
                    end else if (r_idx == LAST_IDX) begin
                        r_out_code   <= r_code;
                        r_out_loc    <= 6'd0;
                        r_out_status <= ST_BAD;
                        r_state      <= S_OUT;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                S_CORR: begin
                    if (w_corr_bad) begin
                        r_out_code   <= r_code;
                        r_out_loc    <= 6'd0;
                        r_out_status <= ST_BAD;
                    end else begin
                        r_out_code   <= w_corr[23:0];
                        r_out_loc    <= r_loc;
                        r_out_status <= ST_FIXED;
                    end
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sec_lut_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sec_lut_search_ctrl
//
// Bench for sec_lut_search_ctrl. It provides the l-LUT (the remainder of a
// signed +/-2^(|l|-1) error mod 3349) and a reference model. The model
// works from whole-number arithmetic: code % A, then a sweep of the
// candidate order, then a range check. A single transaction task drives
// each codeword and compares lut_l, handshakes and results on every falling
// edge.
// ---------------------------------------------------------------------------
module tb_sec_lut_search_ctrl;

    localparam longint A    = 3349;
    localparam longint MAXC = 16777215;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_code;
    logic [5:0]  lut_l;
    logic [11:0] lut_r;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_code;
    logic [5:0]  out_loc;
    logic [1:0]  out_status;

    int  errors = 0;
    int  checks = 0;
    time last_accept_t;

    typedef struct {
        int          rem;
        int          last;    // last search index driven, -1 if no search
        int          lat;     // edge after which out_valid must be high
        logic [23:0] code;
        int          loc;
        int          status;
    } model_t;

    sec_lut_search_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .lut_l      (lut_l),
        .lut_r      (lut_r),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .out_loc    (out_loc),
        .out_status (out_status)
    );

    always #5 clk = ~clk;

    function automatic int loc_of(input int i);
        return (i % 2 == 0) ? (i / 2 + 1) : -(i / 2 + 1);
    endfunction

    function automatic logic [11:0] syn_of(input int l);
        longint v;
        if (l == 0) return 12'd0;
        v = longint'(1) << ((l > 0 ? l : -l) - 1);
        if (l < 0) v = -v;
        v = ((v % A) + A) % A;
        return 12'(v);
    endfunction

    // External l-LUT: combinational in lut_l.
    always_comb lut_r = syn_of(int'($signed(lut_l)));

    function automatic model_t model(input logic [23:0] c);
        model_t m;
        longint e;
        longint cand;
        int     l;
        m.rem    = int'(longint'(c) % A);
        m.code   = c;
        m.loc    = 0;
        m.status = 2;
        m.last   = 47;
        m.lat    = 72;
        if (m.rem == 0) begin
            m.status = 0;
            m.lat    = 24;
            m.last   = -1;
            return m;
        end
        for (int i = 0; i < 48; i++) begin
            l = loc_of(i);
            if (int'(syn_of(l)) == m.rem) begin
                m.last = i;
                m.lat  = 26 + i;
                e      = longint'(1) << ((l > 0 ? l : -l) - 1);
                cand   = (l > 0) ? (longint'(c) - e) : (longint'(c) + e);
                if (cand >= 0 && cand <= MAXC) begin
                    m.code   = cand[23:0];
                    m.loc    = l;
                    m.status = 1;
                end
                return m;
            end
        end
        return m;
    endfunction

    // lut_l expected right after edge Ek (E0 = accept).
    function automatic int exp_lut(input model_t m, input int k);
        if (m.last >= 0 && k >= 24 && k <= 24 + m.last) return loc_of(k - 24);
        return 0;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"},  longint'(out_valid), 0);
        check({tag, "_lut_l"},      longint'($signed(lut_l)), 0);
        check({tag, "_out_code"},   longint'(out_code), 0);
        check({tag, "_out_loc"},    longint'($signed(out_loc)), 0);
        check({tag, "_out_status"}, longint'(out_status), 0);
    endtask

    // Drive one codeword and follow it to the output handshake. abort_k >= 0
    // asserts reset right after edge E(abort_k) instead.
    task automatic run_txn(input logic [23:0] code, input int hold, input int abort_k);
        model_t m;
        int     k;
        int     waited;
        bit     done;
        m = model(code);
        if (clk) @(negedge clk);
        check("in_ready_idle", longint'(in_ready), 1);
        in_valid = 1'b1;
        in_code  = code;
        @(posedge clk);
        last_accept_t = $time;
        k      = 0;
        waited = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (k == abort_k) begin
                check("abort_lut_l", longint'($signed(lut_l)), exp_lut(m, k));
                in_valid = 1'b0;
                rst_n    = 1'b0;
                #1;
                check_reset_outputs("abort");
                check("abort_in_ready", longint'(in_ready), 1);
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                check("abort_release_in_ready", longint'(in_ready), 1);
                check_reset_outputs("abort_release");
                return;
            end
            check("lut_l", longint'($signed(lut_l)), exp_lut(m, k));
            check("out_valid", longint'(out_valid), longint'(k >= m.lat));
            check("in_ready_busy", longint'(in_ready), 0);
            if (k >= m.lat) begin
                check("out_code",   longint'(out_code), longint'(m.code));
                check("out_loc",    longint'($signed(out_loc)), m.loc);
                check("out_status", longint'(out_status), m.status);
                in_valid = 1'b0;
                if (waited == hold) begin
                    out_ready = 1'b1;
                    done      = 1'b1;
                end else begin
                    waited++;
                end
            end else begin
                // Offers while busy must be ignored.
                in_valid = 1'($urandom);
                in_code  = 24'($urandom);
            end
            if (!done && k > 120) begin
                checks++;
                errors++;
                $display("FAIL timeout: out_valid not seen, got %0d cycles expected %0d", k, m.lat);
                in_valid = 1'b0;
                done     = 1'b1;
            end
            k++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_cleared", longint'(out_valid), 0);
        check("in_ready_back", longint'(in_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_t m;
        time    t1;
        longint v;
        longint x;
        int     b;
        int     sel;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 24'd0;
        out_ready = 1'b0;

        // Hand-computed pins on the reference model itself.
        m = model(24'd3349000);
        check("pin_noerr_status", m.status, 0);
        check("pin_noerr_lat", m.lat, 24);
        m = model(24'd3349001);
        check("pin_p1_loc", m.loc, 1);
        check("pin_p1_code", longint'(m.code), 3349000);
        check("pin_p1_lat", m.lat, 26);
        m = model(24'd3344904);
        check("pin_m13_rem", m.rem, 2602);
        check("pin_m13_loc", m.loc, -13);
        check("pin_m13_lat", m.lat, 51);
        m = model(24'd3349003);
        check("pin_dbl_status", m.status, 2);
        check("pin_dbl_lat", m.lat, 72);
        m = model(24'd2);
        check("pin_two_code", longint'(m.code), 0);
        check("pin_two_status", m.status, 1);
        m = model(24'd3);
        check("pin_three_status", m.status, 2);

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("reset_in_ready", longint'(in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", longint'(in_ready), 1);
        check_reset_outputs("release");

        // Directed cases.
        run_txn(24'd3349000, 0, -1);
        run_txn(24'd3349001, 0, -1);
        run_txn(24'd3344904, 0, -1);
        run_txn(24'd3349003, 0, -1);
        t1 = last_accept_t;
        run_txn(24'd3, 0, -1);
        check("accept_to_accept_cycles", longint'((last_accept_t - t1) / 10), 74);
        run_txn(24'd2, 0, -1);
        run_txn(24'd3349001, 10, -1);
        // Reset while the search drives idx 10.
        run_txn(24'd3349003, 0, 34);
        run_txn(24'd3349001, 0, -1);

        // Randomized codewords: clean, +/-2^b errors, arbitrary words.
        for (int n = 0; n < 40; n++) begin
            x   = longint'($urandom_range(0, 5009));
            sel = int'($urandom_range(0, 3));
            b   = int'($urandom_range(0, 23));
            case (sel)
                0:       v = x * A;
                1:       v = x * A + (longint'(1) << b);
                2:       v = x * A - (longint'(1) << b);
                default: v = longint'($urandom_range(0, 32'hFF_FFFF));
            endcase
            if (v < 0 || v > MAXC) v = x * A;
            run_txn(v[23:0], int'($urandom_range(0, 3)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
